irq_ctrl: RTL and testbench

Interrupt controller that sits directly downstream of `timer`. It latches one-cycle event pulses from `timer.signal` and other peripheral sources into pending bits, then applies a software-written mask. It presents one prioritised, stable interrupt request to the CPU core and holds it until the core acknowledges. Lost events, meaning a pulse on a source that is already pending, are recorded as sticky overrun flags.

---
 rtl/irq_ctrl_pkg.sv | 21 ++
 rtl/irq_ctrl_prio_enc.sv | 31 +++
 rtl/irq_ctrl.sv | 118 +++++++++++
 tb/tb_irq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl_pkg
//  Purpose  : Shared definitions for the interrupt controller: default source
//             count / id width and the request FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package irq_ctrl_pkg;

   localparam int IRQ_N_DEFAULT = 8;
   localparam int IRQ_W_DEFAULT = 3;

   // 2'b11 is never entered; the FSM treats it as IDLE.
   typedef enum logic [1:0] {
      IRQ_IDLE = 2'd0,
      IRQ_REQ  = 2'd1,
      IRQ_HOLD = 2'd2
   } irq_state_e;

endpackage
`default_nettype wire

// File: rtl/irq_ctrl_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : prio_enc
//  Purpose  : Combinational lowest-index-first priority encoder.
//  Ports    : req   in  N  request vector
//             id    out W  index of lowest set bit (0 when none set)
//             valid out 1  at least one request bit set
//  Revision : 1.0  initial release
// ============================================================================
module prio_enc #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] id,
   output logic         valid
);

   always_comb begin
      id    = '0;
      valid = |req;
      // Scan downwards so the lowest set index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            id = W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl
//  Purpose  : Latches one-cycle event pulses into pending bits, masks them and
//             presents one prioritised, stable request to the core until it is
//             acknowledged. Pulses on already-pending sources set sticky
//             overrun flags.
//  Ports    : clk, reset_n (sync, active low)
//             src[N]      event pulses          mask_we / mask_wdata[N]
//             ack         core acknowledge      ovr_clr  clear overruns
//             irq, irq_id[W]  registered request and its source id
//             mask[N], pending[N], overrun[N]  register views
//  Revision : 1.0  initial release
// ============================================================================
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int N = IRQ_N_DEFAULT,
   parameter int W = IRQ_W_DEFAULT
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] src,
   input  logic         mask_we,
   input  logic [N-1:0] mask_wdata,
   input  logic         ack,
   input  logic         ovr_clr,
   output logic         irq,
   output logic [W-1:0] irq_id,
   output logic [N-1:0] mask,
   output logic [N-1:0] pending,
   output logic [N-1:0] overrun
);

   irq_state_e   state_q, state_d;
   logic         irq_q, irq_d;
   logic [W-1:0] irq_id_q, irq_id_d;
   logic [N-1:0] pending_q, pending_d;
   logic [N-1:0] mask_q, mask_d;
   logic [N-1:0] overrun_q, overrun_d;

   logic         ack_accept;
   logic [N-1:0] clr_vec;
   logic [W-1:0] win_id;
   logic         win_valid;

   prio_enc #(
      .N (N),
      .W (W)
   ) u_prio_enc (
      .req   (pending_q & mask_q),
      .id    (win_id),
      .valid (win_valid)
   );

   // An ack only counts while a request is actually being presented.
   assign ack_accept = (state_q == IRQ_REQ) && ack;
   assign clr_vec    = ack_accept ? (N'(1) << irq_id_q) : '0;

   always_comb begin
      // A new pulse beats a same-cycle clear, so the bit stays pending.
      pending_d = (pending_q & ~clr_vec) | src;
      // A pulse on a bit being cleared this cycle is a fresh event, not a loss.
      overrun_d = (ovr_clr ? '0 : overrun_q) | (src & pending_q & ~clr_vec);
      mask_d    = mask_we ? mask_wdata : mask_q;
   end

   always_comb begin
      state_d  = state_q;
      irq_id_d = irq_id_q;
      unique case (state_q)
         IRQ_IDLE: begin
            if (win_valid) begin
               irq_id_d = win_id;
               state_d  = IRQ_REQ;
            end
         end
         IRQ_REQ: begin
            if (ack) begin
               state_d = IRQ_HOLD;
            end
         end
         IRQ_HOLD: begin
            state_d = IRQ_IDLE;
         end
         default: begin
            state_d = IRQ_IDLE;
         end
      endcase
      irq_d = (state_d == IRQ_REQ);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IRQ_IDLE;
         irq_q     <= 1'b0;
         irq_id_q  <= '0;
         pending_q <= '0;
         mask_q    <= '0;
         overrun_q <= '0;
      end else begin
         state_q   <= state_d;
         irq_q     <= irq_d;
         irq_id_q  <= irq_id_d;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         overrun_q <= overrun_d;
      end
   end

   assign irq     = irq_q;
   assign irq_id  = irq_id_q;
   assign mask    = mask_q;
   assign pending = pending_q;
   assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_ctrl
//  Purpose  : Self-checking bench for irq_ctrl. A driver issues directed and
//             random stimulus, advances a behavioural model and queues the
//             expected register view; a monitor pops and compares each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_irq_ctrl;

   localparam int N = 8;
   localparam int W = 3;

   typedef struct packed {
      logic         irq;
      logic [W-1:0] irq_id;
      logic [N-1:0] mask;
      logic [N-1:0] pending;
      logic [N-1:0] overrun;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [N-1:0] src = '0;
   logic         mask_we = 1'b0;
   logic [N-1:0] mask_wdata = '0;
   logic         ack = 1'b0;
   logic         ovr_clr = 1'b0;
   logic         irq;
   logic [W-1:0] irq_id;
   logic [N-1:0] mask;
   logic [N-1:0] pending;
   logic [N-1:0] overrun;

   int n_cmp = 0;
   int n_err = 0;
   exp_t sb[$];

   irq_ctrl #(.N(N), .W(W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .src        (src),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .ack        (ack),
      .ovr_clr    (ovr_clr),
      .irq        (irq),
      .irq_id     (irq_id),
      .mask       (mask),
      .pending    (pending),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // A request is either outstanding (m_req) or not; after an acknowledge the
   // controller stays quiet for m_gap more edges before granting again.
   bit       m_pend [N];
   bit       m_mask [N];
   bit       m_ovr  [N];
   bit       m_req;
   int       m_id;
   int       m_gap;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0; m_mask[i] = 0; m_ovr[i] = 0;
      end
      m_req = 0; m_id = 0; m_gap = 0;
   endtask

   task automatic model_step(input logic [N-1:0] s, input logic mwe,
                             input logic [N-1:0] mwd, input logic a,
                             input logic oc, input logic rn);
      bit accepted;
      int winner;
      if (!rn) begin
         model_reset();
         return;
      end
      accepted = m_req && a;
      winner = -1;
      for (int i = N - 1; i >= 0; i--)
         if (m_pend[i] && m_mask[i]) winner = i;
      for (int i = 0; i < N; i++) begin
         bit cleared;
         cleared   = accepted && (m_id == i);
         m_ovr[i]  = (s[i] && m_pend[i] && !cleared) || (m_ovr[i] && !oc);
         m_pend[i] = s[i] || (m_pend[i] && !cleared);
         if (mwe) m_mask[i] = mwd[i];
      end
      if (m_req) begin
         if (accepted) begin
            m_req = 0;
            m_gap = 1;
         end
      end else if (m_gap > 0) begin
         m_gap = m_gap - 1;
      end else if (winner >= 0) begin
         m_req = 1;
         m_id  = winner;
      end
   endtask

   function automatic exp_t model_view();
      exp_t e;
      e.irq    = m_req;
      e.irq_id = W'(m_id);
      for (int i = 0; i < N; i++) begin
         e.mask[i]    = m_mask[i];
         e.pending[i] = m_pend[i];
         e.overrun[i] = m_ovr[i];
      end
      return e;
   endfunction

   // ---------------- driver ----------------
   task automatic step(input logic [N-1:0] s, input logic mwe,
                       input logic [N-1:0] mwd, input logic a,
                       input logic oc, input logic rn);
      @(negedge clk);
      src = s; mask_we = mwe; mask_wdata = mwd; ack = a; ovr_clr = oc;
      reset_n = rn;
      model_step(s, mwe, mwd, a, oc, rn);
      sb.push_back(model_view());
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step('0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic pulse(input logic [N-1:0] s);
      step(s, 1'b0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic wmask(input logic [N-1:0] m);
      step('0, 1'b1, m, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_ack();
      step('0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
   endtask

   // ---------------- monitor ----------------
   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("irq",     32'(irq),     32'(e.irq));
         check("irq_id",  32'(irq_id),  32'(e.irq_id));
         check("mask",    32'(mask),    32'(e.mask));
         check("pending", 32'(pending), 32'(e.pending));
         check("overrun", 32'(overrun), 32'(e.overrun));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      for (int k = 0; k < 3; k++) step('0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Single timer source: request two cycles after pulse, ack drops it.
      wmask(8'h01);
      idle(2);
      pulse(8'h01);
      idle(4);
      do_ack();
      idle(3);

      // Two simultaneous sources: id 5 first, id 7 three cycles after ack.
      wmask(8'hFF);
      pulse(8'b1010_0000);
      idle(3);
      do_ack();
      idle(4);
      do_ack();
      idle(3);

      // Masked source stays pending; enabling it raises the request.
      wmask(8'h00);
      pulse(8'h04);
      idle(3);
      wmask(8'h04);
      idle(3);
      do_ack();
      idle(3);

      // Overrun on repeated pulse, then cleared.
      wmask(8'h00);
      pulse(8'h01);
      idle(4);
      pulse(8'h01);
      idle(2);
      step('0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
      idle(2);

      // Ack and new pulse on the presented source in the same cycle.
      step('0, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
      wmask(8'h08);
      pulse(8'h08);
      idle(3);
      step(8'h08, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      idle(5);

      // Reset while a request is presented.
      step('0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      idle(5);

      // Randomised traffic.
      wmask(8'hFF);
      for (int k = 0; k < 400; k++) begin
         logic [N-1:0] s;
         logic mwe, a, oc, rn;
         s   = ($urandom_range(0, 3) == 0) ? N'($urandom & $urandom) : '0;
         mwe = ($urandom_range(0, 19) == 0);
         a   = ($urandom_range(0, 2) == 0);
         oc  = ($urandom_range(0, 24) == 0);
         rn  = ($urandom_range(0, 149) != 0);
         step(s, mwe, N'($urandom), a, oc, rn);
      end
      idle(3);

      @(posedge clk);
      @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
